// File: rtl/rab_target_arb.sv
// rab_target_arb
// Responder end of the register access bus. Two initiators (the MCU XRAM
// window and the I2C slave) post single-cycle read/write strobes; each request
// is latched in a per-initiator pending slot, a round-robin arbiter picks one,
// and a small FSM performs the access on the register-file port before
// returning a one-cycle ack (with read data for reads) to that initiator.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mcu_rab_*  / i2c_rab_*       initiator strobes, address, write data in;
//                                ack pulse and held read data out
//   reg_addr, reg_wdata          register-file address / write data
//   reg_wr, reg_rd               register-file one-cycle write / read strobes
//   reg_rdata                    register-file read data, valid after reg_rd
//   rab_busy                     an access is in progress
module rab_target_arb #(
  parameter int RAB_ADDR_WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mcu_rab_write,
  input  logic                      mcu_rab_read,
  input  logic [RAB_ADDR_WIDTH-1:0] mcu_rab_addr,
  input  logic [7:0]                mcu_rab_wdata,
  output logic                      mcu_rab_ack,
  output logic [7:0]                mcu_rab_rdata,
  input  logic                      i2c_rab_write,
  input  logic                      i2c_rab_read,
  input  logic [RAB_ADDR_WIDTH-1:0] i2c_rab_addr,
  input  logic [7:0]                i2c_rab_wdata,
  output logic                      i2c_rab_ack,
  output logic [7:0]                i2c_rab_rdata,
  output logic [RAB_ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]                reg_wdata,
  output logic                      reg_wr,
  output logic                      reg_rd,
  input  logic [7:0]                reg_rdata,
  output logic                      rab_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    ACK   = 2'd3
  } state_e;

  localparam logic GNT_MCU = 1'b0;
  localparam logic GNT_I2C = 1'b1;

  state_e                    state_q, state_d;
  logic                      last_grant_q, last_grant_d;

  logic                      mcu_pend_q, mcu_pend_d;
  logic [RAB_ADDR_WIDTH-1:0] mcu_addr_q, mcu_addr_d;
  logic [7:0]                mcu_wdata_q, mcu_wdata_d;
  logic                      mcu_wr_q, mcu_wr_d;
  logic [7:0]                mcu_rdata_q, mcu_rdata_d;

  logic                      i2c_pend_q, i2c_pend_d;
  logic [RAB_ADDR_WIDTH-1:0] i2c_addr_q, i2c_addr_d;
  logic [7:0]                i2c_wdata_q, i2c_wdata_d;
  logic                      i2c_wr_q, i2c_wr_d;
  logic [7:0]                i2c_rdata_q, i2c_rdata_d;

  logic [RAB_ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]                sel_wdata;
  logic                      sel_wr;

  // last_grant doubles as the current grant: it is updated on the IDLE->ISSUE
  // transition and stays stable for the whole access.
  always_comb begin
    if (last_grant_q == GNT_MCU) begin
      sel_addr  = mcu_addr_q;
      sel_wdata = mcu_wdata_q;
      sel_wr    = mcu_wr_q;
    end else begin
      sel_addr  = i2c_addr_q;
      sel_wdata = i2c_wdata_q;
      sel_wr    = i2c_wr_q;
    end
  end

  // Access sequencer: arbitrate in IDLE, strobe the register file in ISSUE,
  // wait one cycle for read data in RWAIT, and pulse the ack in ACK.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    reg_wr       = 1'b0;
    reg_rd       = 1'b0;
    mcu_rab_ack  = 1'b0;
    i2c_rab_ack  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mcu_pend_q && i2c_pend_q) begin
          last_grant_d = ~last_grant_q;
          state_d      = ISSUE;
        end else if (mcu_pend_q) begin
          last_grant_d = GNT_MCU;
          state_d      = ISSUE;
        end else if (i2c_pend_q) begin
          last_grant_d = GNT_I2C;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (sel_wr) begin
          reg_wr  = 1'b1;
          state_d = ACK;
        end else begin
          reg_rd  = 1'b1;
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        state_d = ACK;
      end
      ACK: begin
        if (last_grant_q == GNT_MCU) begin
          mcu_rab_ack = 1'b1;
        end else begin
          i2c_rab_ack = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request slots. A strobe is taken only into an empty slot, or into the slot
  // being acked this cycle so that back-to-back requests are not lost. A
  // simultaneous read+write is latched as a write.
  always_comb begin
    mcu_pend_d  = mcu_pend_q;
    mcu_addr_d  = mcu_addr_q;
    mcu_wdata_d = mcu_wdata_q;
    mcu_wr_d    = mcu_wr_q;
    i2c_pend_d  = i2c_pend_q;
    i2c_addr_d  = i2c_addr_q;
    i2c_wdata_d = i2c_wdata_q;
    i2c_wr_d    = i2c_wr_q;
    if ((!mcu_pend_q || mcu_rab_ack) && (mcu_rab_write || mcu_rab_read)) begin
      mcu_pend_d  = 1'b1;
      mcu_addr_d  = mcu_rab_addr;
      mcu_wdata_d = mcu_rab_wdata;
      mcu_wr_d    = mcu_rab_write;
    end else if (mcu_rab_ack) begin
      mcu_pend_d  = 1'b0;
    end
    if ((!i2c_pend_q || i2c_rab_ack) && (i2c_rab_write || i2c_rab_read)) begin
      i2c_pend_d  = 1'b1;
      i2c_addr_d  = i2c_rab_addr;
      i2c_wdata_d = i2c_rab_wdata;
      i2c_wr_d    = i2c_rab_write;
    end else if (i2c_rab_ack) begin
      i2c_pend_d  = 1'b0;
    end
  end

  // Read data is captured only in RWAIT for the granted initiator, so each
  // initiator's rdata holds until its own next read completes.
  always_comb begin
    mcu_rdata_d = mcu_rdata_q;
    i2c_rdata_d = i2c_rdata_q;
    if (state_q == RWAIT) begin
      if (last_grant_q == GNT_MCU) begin
        mcu_rdata_d = reg_rdata;
      end else begin
        i2c_rdata_d = reg_rdata;
      end
    end
  end

  // Reset leaves last_grant on I2C so the MCU wins the first tie, and drops
  // any in-flight access without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I2C;
      mcu_pend_q   <= 1'b0;
      mcu_addr_q   <= '0;
      mcu_wdata_q  <= '0;
      mcu_wr_q     <= 1'b0;
      mcu_rdata_q  <= '0;
      i2c_pend_q   <= 1'b0;
      i2c_addr_q   <= '0;
      i2c_wdata_q  <= '0;
      i2c_wr_q     <= 1'b0;
      i2c_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mcu_pend_q   <= mcu_pend_d;
      mcu_addr_q   <= mcu_addr_d;
      mcu_wdata_q  <= mcu_wdata_d;
      mcu_wr_q     <= mcu_wr_d;
      mcu_rdata_q  <= mcu_rdata_d;
      i2c_pend_q   <= i2c_pend_d;
      i2c_addr_q   <= i2c_addr_d;
      i2c_wdata_q  <= i2c_wdata_d;
      i2c_wr_q     <= i2c_wr_d;
      i2c_rdata_q  <= i2c_rdata_d;
    end
  end

  assign reg_addr      = (state_q != IDLE) ? sel_addr : '0;
  assign reg_wdata     = (state_q != IDLE) ? sel_wdata : '0;
  assign rab_busy      = (state_q != IDLE);
  assign mcu_rab_rdata = mcu_rdata_q;
  assign i2c_rab_rdata = i2c_rdata_q;

endmodule

// File: tb/tb_rab_target_arb.sv
// tb_rab_target_arb
// Directed bench for rab_target_arb. A transaction-level model (pending slots,
// a round-robin pick and a per-access timeline) predicts every output on every
// cycle; directed scenarios add literal expectations at specific cycles.
module tb_rab_target_arb;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mcu_rab_write = 1'b0, mcu_rab_read = 1'b0;
  logic [AW-1:0] mcu_rab_addr = '0;
  logic [7:0]    mcu_rab_wdata = '0;
  logic          mcu_rab_ack;
  logic [7:0]    mcu_rab_rdata;
  logic          i2c_rab_write = 1'b0, i2c_rab_read = 1'b0;
  logic [AW-1:0] i2c_rab_addr = '0;
  logic [7:0]    i2c_rab_wdata = '0;
  logic          i2c_rab_ack;
  logic [7:0]    i2c_rab_rdata;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_wr, reg_rd;
  logic [7:0]    reg_rdata = '0;
  logic          rab_busy;

  rab_target_arb #(.RAB_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .mcu_rab_write(mcu_rab_write), .mcu_rab_read(mcu_rab_read),
    .mcu_rab_addr(mcu_rab_addr), .mcu_rab_wdata(mcu_rab_wdata),
    .mcu_rab_ack(mcu_rab_ack), .mcu_rab_rdata(mcu_rab_rdata),
    .i2c_rab_write(i2c_rab_write), .i2c_rab_read(i2c_rab_read),
    .i2c_rab_addr(i2c_rab_addr), .i2c_rab_wdata(i2c_rab_wdata),
    .i2c_rab_ack(i2c_rab_ack), .i2c_rab_rdata(i2c_rab_rdata),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .rab_busy(rab_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  // Cycle counter used to place directed checks relative to a strobe.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register file responder: reads return memory contents the cycle after
  // reg_rd; otherwise reg_rdata carries noise the DUT must not capture.
  logic [7:0]    mem [512];
  logic          rdReq = 1'b0;
  logic [AW-1:0] rdAddr = '0;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[9'h1FF] = 8'h3C;
  end

  always @(negedge clk) begin
    rdReq  = (reg_rd === 1'b1);
    rdAddr = reg_addr;
    if (reg_wr === 1'b1) mem[reg_addr] = reg_wdata;
  end

  always @(posedge clk) begin
    #1;
    if (rdReq) reg_rdata = mem[rdAddr];
    else       reg_rdata = 8'($urandom);
  end

  // Behavioural model: index 0 is the MCU, 1 is the I2C slave. An access is
  // granted in an idle cycle, strobes the register file one cycle later and
  // acks 2 (write) or 3 (read) cycles after the grant.
  bit            mValid = 0;
  bit            mPend [2];
  logic [AW-1:0] mAddr [2];
  logic [7:0]    mWdata [2];
  bit            mIsWr [2];
  logic [7:0]    mRdata [2];
  bit            mActive;
  int            mWho, mStep, mLen, mLast;
  bit            clr [2];
  bit            sw [2], sr [2];
  logic [AW-1:0] sa [2];
  logic [7:0]    sd [2];
  logic          eWr, eRd, eAckM, eAckI, eBusy;
  logic [AW-1:0] eAddr;
  logic [7:0]    eWdata;

  int            ackLog [$];
  bit            logAcks = 0;
  int            rdPulses = 0;
  int            i2cAcks = 0;

  always @(negedge clk) begin
    if (mValid) begin
      eWr = 0; eRd = 0; eAckM = 0; eAckI = 0; eBusy = 0; eAddr = '0; eWdata = '0;
      if (mActive) begin
        eBusy  = 1;
        eAddr  = mAddr[mWho];
        eWdata = mWdata[mWho];
        if (mStep == 1) begin
          eWr = mIsWr[mWho];
          eRd = !mIsWr[mWho];
        end
        if (mStep == mLen) begin
          if (mWho == 0) eAckM = 1;
          else           eAckI = 1;
        end
      end
      checkOutput("m_reg_wr",    32'(reg_wr),        32'(eWr));
      checkOutput("m_reg_rd",    32'(reg_rd),        32'(eRd));
      checkOutput("m_reg_addr",  32'(reg_addr),      32'(eAddr));
      checkOutput("m_reg_wdata", 32'(reg_wdata),     32'(eWdata));
      checkOutput("m_mcu_ack",   32'(mcu_rab_ack),   32'(eAckM));
      checkOutput("m_i2c_ack",   32'(i2c_rab_ack),   32'(eAckI));
      checkOutput("m_mcu_rdata", 32'(mcu_rab_rdata), 32'(mRdata[0]));
      checkOutput("m_i2c_rdata", 32'(i2c_rab_rdata), 32'(mRdata[1]));
      checkOutput("m_busy",      32'(rab_busy),      32'(eBusy));
      checkOutput("wr_rd_excl",  32'(reg_wr & reg_rd), 32'(0));
      checkOutput("ack_excl",    32'(mcu_rab_ack & i2c_rab_ack), 32'(0));
      if (logAcks && mcu_rab_ack === 1'b1) ackLog.push_back(0);
      if (logAcks && i2c_rab_ack === 1'b1) ackLog.push_back(1);
      if (reg_rd === 1'b1) rdPulses++;
      if (i2c_rab_ack === 1'b1) i2cAcks++;
    end
    if (rst) begin
      mValid  = 1;
      mActive = 0;
      mLast   = 1;
      for (int i = 0; i < 2; i++) begin
        mPend[i] = 0; mAddr[i] = '0; mWdata[i] = '0; mIsWr[i] = 0; mRdata[i] = '0;
      end
    end else if (mValid) begin
      for (int i = 0; i < 2; i++) clr[i] = mActive && (mStep == mLen) && (mWho == i);
      if (mActive) begin
        if (!mIsWr[mWho] && mStep == 2) mRdata[mWho] = reg_rdata;
        if (mStep == mLen) mActive = 0;
        else               mStep++;
      end else if (mPend[0] || mPend[1]) begin
        if (mPend[0] && mPend[1]) mWho = 1 - mLast;
        else                      mWho = mPend[0] ? 0 : 1;
        mLast   = mWho;
        mActive = 1;
        mStep   = 1;
        mLen    = mIsWr[mWho] ? 2 : 3;
      end
      sw[0] = mcu_rab_write; sr[0] = mcu_rab_read; sa[0] = mcu_rab_addr; sd[0] = mcu_rab_wdata;
      sw[1] = i2c_rab_write; sr[1] = i2c_rab_read; sa[1] = i2c_rab_addr; sd[1] = i2c_rab_wdata;
      for (int i = 0; i < 2; i++) begin
        if ((!mPend[i] || clr[i]) && (sw[i] || sr[i])) begin
          mPend[i]  = 1;
          mAddr[i]  = sa[i];
          mWdata[i] = sd[i];
          mIsWr[i]  = sw[i];
        end else if (clr[i]) begin
          mPend[i] = 0;
        end
      end
    end
  end

  // Drive one cycle of strobes (cycle 0 of a scenario), then release them and
  // scramble the address/data buses so later changes cannot leak through.
  task automatic applyStimulus(input logic mw, input logic mr, input logic [AW-1:0] ma,
                               input logic [7:0] md, input logic iw, input logic ir,
                               input logic [AW-1:0] ia, input logic [7:0] id);
    @(posedge clk); #1;
    mcu_rab_write = mw; mcu_rab_read = mr; mcu_rab_addr = ma; mcu_rab_wdata = md;
    i2c_rab_write = iw; i2c_rab_read = ir; i2c_rab_addr = ia; i2c_rab_wdata = id;
    base = cyc;
    @(posedge clk); #1;
    mcu_rab_write = 0; mcu_rab_read = 0; mcu_rab_addr = ~ma; mcu_rab_wdata = ~md;
    i2c_rab_write = 0; i2c_rab_read = 0; i2c_rab_addr = ~ia; i2c_rab_wdata = ~id;
  endtask

  task automatic toCycle(input int k);
    while (cyc < base + k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic atCycle(input int k);
    if (cyc > base + k) checkOutput("cycle_order", 32'(cyc - base), 32'(k));
    toCycle(k);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idle(2);
    rst = 0;
    @(negedge clk);
    checkOutput("rst_busy",      32'(rab_busy),      32'(0));
    checkOutput("rst_reg_addr",  32'(reg_addr),      32'(0));
    checkOutput("rst_mcu_rdata", 32'(mcu_rab_rdata), 32'(0));

    $display("[TB] MCU write");
    applyStimulus(1, 0, 9'h010, 8'hA5, 0, 0, 9'h000, 8'h00);
    atCycle(2);
    checkOutput("wr_reg_wr",    32'(reg_wr),    32'(1));
    checkOutput("wr_reg_addr",  32'(reg_addr),  32'h010);
    checkOutput("wr_reg_wdata", 32'(reg_wdata), 32'hA5);
    atCycle(3);
    checkOutput("wr_mcu_ack",   32'(mcu_rab_ack), 32'(1));
    checkOutput("wr_i2c_ack",   32'(i2c_rab_ack), 32'(0));
    atCycle(4);
    checkOutput("wr_ack_gone",  32'(mcu_rab_ack), 32'(0));
    idle(3);

    $display("[TB] MCU read");
    applyStimulus(0, 1, 9'h1FF, 8'h00, 0, 0, 9'h000, 8'h00);
    atCycle(2);
    checkOutput("rd_reg_rd",    32'(reg_rd),   32'(1));
    checkOutput("rd_reg_addr",  32'(reg_addr), 32'h1FF);
    atCycle(3);
    checkOutput("rd_no_ack_c3", 32'(mcu_rab_ack), 32'(0));
    atCycle(4);
    checkOutput("rd_mcu_ack",   32'(mcu_rab_ack),   32'(1));
    checkOutput("rd_mcu_rdata", 32'(mcu_rab_rdata), 32'h3C);
    atCycle(14);
    checkOutput("rd_rdata_hold", 32'(mcu_rab_rdata), 32'h3C);

    $display("[TB] contention after reset");
    doReset();
    applyStimulus(1, 0, 9'h020, 8'h11, 0, 1, 9'h030, 8'h00);
    atCycle(2);
    checkOutput("ct_reg_wr",   32'(reg_wr),   32'(1));
    checkOutput("ct_wr_addr",  32'(reg_addr), 32'h020);
    atCycle(3);
    checkOutput("ct_mcu_ack",  32'(mcu_rab_ack), 32'(1));
    atCycle(5);
    checkOutput("ct_reg_rd",   32'(reg_rd),   32'(1));
    checkOutput("ct_rd_addr",  32'(reg_addr), 32'h030);
    atCycle(7);
    checkOutput("ct_i2c_ack",   32'(i2c_rab_ack),   32'(1));
    checkOutput("ct_i2c_rdata", 32'(i2c_rab_rdata), 32'h6A);
    idle(3);

    $display("[TB] continuous requests");
    ackLog.delete();
    logAcks = 1;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      mcu_rab_write = 1; mcu_rab_addr = 9'(9'h100 + j); mcu_rab_wdata = 8'(j);
      i2c_rab_read  = 1; i2c_rab_addr = 9'(j);
    end
    @(posedge clk); #1;
    mcu_rab_write = 0; i2c_rab_read = 0;
    idle(12);
    logAcks = 0;
    for (int k = 0; k < 6; k++)
      checkOutput($sformatf("grant%0d", k),
                  32'((k < ackLog.size()) ? ackLog[k] : 9), 32'(k % 2));

    $display("[TB] strobe while pending");
    rdPulses = 0;
    applyStimulus(0, 1, 9'h040, 8'h00, 0, 0, 9'h000, 8'h00);
    mcu_rab_read = 1; mcu_rab_addr = 9'h050;
    @(posedge clk); #1;
    mcu_rab_read = 0;
    atCycle(2);
    checkOutput("pd_reg_addr",  32'(reg_addr), 32'h040);
    atCycle(4);
    checkOutput("pd_mcu_rdata", 32'(mcu_rab_rdata), 32'h1A);
    atCycle(10);
    checkOutput("pd_rd_count",  32'(rdPulses), 32'(1));

    $display("[TB] reset mid-read");
    i2cAcks = 0;
    applyStimulus(0, 0, 9'h000, 8'h00, 0, 1, 9'h060, 8'h00);
    toCycle(3);
    rst = 1;
    toCycle(4);
    rst = 0;
    @(negedge clk);
    checkOutput("ab_busy",      32'(rab_busy),      32'(0));
    checkOutput("ab_reg_addr",  32'(reg_addr),      32'(0));
    checkOutput("ab_i2c_rdata", 32'(i2c_rab_rdata), 32'(0));
    atCycle(10);
    checkOutput("ab_no_ack",    32'(i2cAcks), 32'(0));
    applyStimulus(1, 0, 9'h070, 8'h5C, 0, 0, 9'h000, 8'h00);
    atCycle(2);
    checkOutput("ab_reg_wr",    32'(reg_wr),    32'(1));
    checkOutput("ab_reg_wdata", 32'(reg_wdata), 32'h5C);
    atCycle(3);
    checkOutput("ab_mcu_ack",   32'(mcu_rab_ack), 32'(1));
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rab_target_arb.md
Name: rab_target_arb

Overview:
- Responder end of the register access bus (RAB) driven by the MCU XRAM window (16'hfe00–16'hffff) and by the I2C slave.
- Captures single-cycle read/write request strobes from both initiators and arbitrates between them round-robin.
- Performs one access at a time on the register-file port and returns a one-cycle ack with read data to the granted initiator.

Parameters:
- RAB_ADDR_WIDTH, 9, register address width (512-byte register window).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- mcu_rab_write  input  1  MCU write strobe, one cycle
- mcu_rab_read  input  1  MCU read strobe, one cycle
- mcu_rab_addr  input  RAB_ADDR_WIDTH  MCU register address
- mcu_rab_wdata  input  8  MCU write data
- mcu_rab_ack  output  1  MCU access complete, one-cycle pulse
- mcu_rab_rdata  output  8  MCU read data, valid with ack and held afterwards
- i2c_rab_write  input  1  I2C write strobe, one cycle
- i2c_rab_read  input  1  I2C read strobe, one cycle
- i2c_rab_addr  input  RAB_ADDR_WIDTH  I2C register address
- i2c_rab_wdata  input  8  I2C write data
- i2c_rab_ack  output  1  I2C access complete, one-cycle pulse
- i2c_rab_rdata  output  8  I2C read data, valid with ack and held afterwards
- reg_addr  output  RAB_ADDR_WIDTH  register-file address
- reg_wdata  output  8  register-file write data
- reg_wr  output  1  register-file write, one cycle
- reg_rd  output  1  register-file read, one cycle
- reg_rdata  input  8  register-file read data, valid the cycle after reg_rd
- rab_busy  output  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; both pending flags cleared; FSM in IDLE; last_grant = I2C, so the MCU wins the first tie.
- Request capture, per initiator:
  - If the pending flag is clear, a read or write strobe sets the flag and latches addr, wdata and dir at the clock edge.
  - If write and read are asserted together, the access is treated as a write.
  - A strobe while that initiator's flag is already set is ignored; the latched request is unchanged.
- Pending clear: the flag clears at the end of that initiator's ACK cycle. A new strobe in the ACK cycle itself is captured (set wins over clear).
- FSM states: IDLE, ISSUE, RWAIT, ACK.
  - IDLE: if any flag is set, grant one initiator, go to ISSUE.
    - Only one flag set: grant it.
    - Both set: grant the initiator that is not last_grant.
    - last_grant updates on grant.
  - ISSUE: drive reg_addr and reg_wdata from the granted latch for one cycle.
    - Write: reg_wr = 1, go to ACK.
    - Read: reg_rd = 1, go to RWAIT.
  - RWAIT: sample reg_rdata into the granted initiator's rdata register at the end of the cycle, go to ACK.
  - ACK: assert the granted initiator's ack for exactly one cycle, clear its flag, go to IDLE.
- Latency, with the request strobe in cycle 0:
  - Write: reg_wr in cycle 2, ack in cycle 3.
  - Read: reg_rd in cycle 2, reg_rdata sampled in cycle 3, ack plus valid rdata in cycle 4.
  - Under contention, the losing initiator waits one full transaction plus one IDLE cycle.
- Write ack: rdata is unchanged.
- Read data hold: mcu_rab_rdata and i2c_rab_rdata each hold their last read value until that initiator's next read completes.
- Strobe and ack exclusivity:
  - reg_wr and reg_rd are never both high.
  - Never more than one ack is high in a cycle.
- reg_addr and reg_wdata are driven from the latch while not in IDLE, and are 0 in IDLE.
- Reset mid-operation: the FSM returns to IDLE the next cycle.
  - No ack is issued for the aborted access.
  - Flags are cleared.
  - rdata registers are cleared to 0.
- Address and data are passed through unmodified; no address decoding in this block.

Test Plan:
- MCU write addr 9'h010, data 8'hA5, cycle 0 -> reg_wr=1, reg_addr=9'h010, reg_wdata=8'hA5 in cycle 2; mcu_rab_ack=1 in cycle 3 only; i2c_rab_ack stays 0.
- MCU read addr 9'h1FF, reg_rdata=8'h3C in cycle 3 -> reg_rd in cycle 2; mcu_rab_ack=1 with mcu_rab_rdata=8'h3C in cycle 4; rdata still 8'h3C 10 cycles later.
- MCU write and I2C read in the same cycle after reset -> MCU served first (reg_wr cycle 2, ack cycle 3); I2C reg_rd in cycle 5, i2c_rab_ack in cycle 7.
- Both initiators re-requesting continuously for 6 transactions -> grants alternate MCU, I2C, MCU, ...; no ack overlap.
- MCU read strobe again in cycle 1 while pending, with a different address -> the second strobe is ignored; only one reg_rd, at the original address.
- rst asserted in cycle 3 of an I2C read -> no i2c_rab_ack; all outputs 0 from the cycle after reset; a subsequent MCU write completes with normal 3-cycle latency.
